// File: rtl/addsub_seq_seg_pkg.sv
// Shared definitions for the add/subtract unit with scanned hex display:
// operation encodings and the display digit-count derivation.
package addsub_seq_seg_pkg;

    // op[0] selects subtract, op[1] selects the accumulator as operand A
    typedef enum logic [1:0] {
        OP_ADD     = 2'd0,
        OP_SUB     = 2'd1,
        OP_ACC_ADD = 2'd2,
        OP_ACC_SUB = 2'd3
    } op_e;

    // Hex digits needed for the result plus one digit for the carry flag
    function automatic int digits_of(input int width);
        return (width + 3) / 4 + 1;
    endfunction

endpackage

// File: rtl/bin7seg.sv
// Nibble to seven-segment decoder, active-high segments ordered {g,f,e,d,c,b,a}.
module bin7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup, no state
    always_comb begin
        seg = 7'h00;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/addsub_seq_seg.sv
// Registered add/subtract unit with flags and a multiplexed hex display.
// The result is shown LSB nibble first on digits 0..DIGITS-2; the top digit
// shows the carry flag as 0 or 1.
// Build option ADDSUB_ACCUM_EN: adds a WIDTH-bit accumulator that op[1]
// selects as operand A and that loads every accepted result.
module addsub_seq_seg
    import addsub_seq_seg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [1:0]                     op,
    input  logic [WIDTH-1:0]               a,
    input  logic [WIDTH-1:0]               b,
    output logic [WIDTH-1:0]               result,
    output logic                           carry,
    output logic                           ovf,
    output logic                           zero,
    output logic                           out_valid,
    output logic [6:0]                     seg_out,
    output logic [digits_of(WIDTH)-1:0]    an,
    output logic [2*WIDTH-1:0]             led
);

    localparam int DIGITS = digits_of(WIDTH);
    localparam int PAD_W  = 4 * (DIGITS - 1);
    localparam int CNT_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 2) ? $clog2(DIGITS) : 1;

    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             sum_ovf;

    logic [CNT_W-1:0] scan_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic [PAD_W-1:0] res_pad;
    logic [3:0]       nibble;

`ifdef ADDSUB_ACCUM_EN
    logic [WIDTH-1:0] accum;

    assign a_sel = op[1] ? accum : a;

    // Accumulator tracks the last accepted result
    always_ff @(posedge clk) begin
        if (rst) begin
            accum <= '0;
        end else if (in_valid) begin
            accum <= sum[WIDTH-1:0];
        end
    end
`else
    logic unused_op_hi;

    assign unused_op_hi = op[1];
    assign a_sel        = a;
`endif

    // Subtract is A + ~B + 1; the carry-in doubles as the subtract select
    always_comb begin
        b_eff   = b ^ {WIDTH{op[0]}};
        sum     = {1'b0, a_sel} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op[0]};
        sum_ovf = (a_sel[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum[WIDTH-1] != a_sel[WIDTH-1]);
    end

    // Result, flags and operand echo register on accepted requests only
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
            led       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= sum[WIDTH-1:0];
                carry  <= sum[WIDTH];
                ovf    <= sum_ovf;
                zero   <= (sum[WIDTH-1:0] == '0);
                led    <= {b, a};
            end
        end
    end

    // Scan timer: dwell SCAN_DIV cycles per digit, then step to the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (digit_idx == IDX_W'(DIGITS - 1)) begin
                digit_idx <= '0;
            end else begin
                digit_idx <= digit_idx + 1'b1;
            end
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign res_pad = PAD_W'(result);

    // Digit mux: result nibbles below the top digit, carry on the top digit
    always_comb begin
        nibble = {3'b000, carry};
        for (int i = 0; i < DIGITS - 1; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                nibble = res_pad[i*4 +: 4];
            end
        end
    end

    // One-hot anode enable for the scanned digit
    always_comb begin
        an = '0;
        for (int i = 0; i < DIGITS; i++) begin
            an[i] = (digit_idx == IDX_W'(i));
        end
    end

    bin7seg u_bin7seg (
        .nibble (nibble),
        .seg    (seg_out)
    );

endmodule

// File: doc/addsub_seq_seg.md
ADDSUB_SEQ_SEG -- requirements
Module: addsub_seq_seg

Interface
- REQ-001: Parameter WIDTH, default 8, SHALL set the operand and result width (legal 4..32).
- REQ-002: Parameter SCAN_DIV, default 50000, SHALL set the clock cycles per display digit (legal >= 2).
- REQ-003: Derived constant DIGITS SHALL equal (WIDTH+3)/4 + 1: hex digits of the result plus one carry digit.
- REQ-004: clk, input, 1, sole clock; all state SHALL update on its rising edge.
- REQ-005: rst, input, 1, synchronous active-high reset.
- REQ-006: in_valid, input, 1, operation request; SHALL be sampled every cycle.
- REQ-007: op, input, 2, bit0: 0=add, 1=subtract; bit1: 1=use accumulator as operand A.
- REQ-008: a, input, WIDTH, operand A; b, input, WIDTH, operand B.
- REQ-009: result, output, WIDTH, registered sum or difference.
- REQ-010: carry, output, 1, adder carry-out (for subtract, 1 = no borrow).
- REQ-011: ovf, output, 1, two's-complement signed overflow.
- REQ-012: zero, output, 1, high when result == 0.
- REQ-013: out_valid, output, 1, one-cycle pulse marking new result/flags.
- REQ-014: seg_out, output, 7, segment pattern of the currently scanned digit.
- REQ-015: an, output, DIGITS, one-hot digit enable, active-high.
- REQ-016: led, output, 2*WIDTH, registered {b,a} of the last accepted operation.

Function
- REQ-017: On a cycle with in_valid=1, the block SHALL compute A + (B XOR {WIDTH{op[0]}}) + op[0] and register result, carry, ovf, zero, led and out_valid=1 on the next edge (latency 1).
- REQ-018: Throughput SHALL be one operation per cycle; back-to-back in_valid SHALL produce back-to-back out_valid pulses.
- REQ-019: With in_valid=0, result/carry/ovf/zero/led SHALL hold; out_valid SHALL be 0.
- REQ-020: ovf SHALL be (A[MSB]==B'[MSB]) && (result[MSB]!=A[MSB]), where B' is the inverted-or-not B.
- REQ-021: Scan counter SHALL count 0..SCAN_DIV-1; at terminal count the digit index SHALL advance, wrapping from DIGITS-1 to 0.
- REQ-022: an SHALL have bit [index] set; digits 0..DIGITS-2 SHALL show result nibbles (LSB first, top nibble zero-padded); digit DIGITS-1 SHALL show carry as 0 or 1.
- REQ-023: seg_out SHALL be combinationally decoded from the selected nibble via the shared hex decoder; result updates SHALL be visible on the next scan without resetting the scan counter.

Reset
- REQ-024: rst=1 SHALL override in_valid in the same cycle; no operation is accepted.
- REQ-025: After reset: result=0, carry=0, ovf=0, zero=1, out_valid=0, led=0, accumulator=0, scan counter=0, an=1 (digit 0), seg_out = decoder pattern for 0.

Configuration
- REQ-026: Macro ADDSUB_ACCUM_EN defined: op[1]=1 SHALL take A from an internal WIDTH-bit accumulator, and the accumulator SHALL load result on every accepted operation.
- REQ-027: Macro ADDSUB_ACCUM_EN undefined: no accumulator register exists; op[1] SHALL be ignored and A always comes from port a.

Structure
- REQ-028: A shared package SHALL hold op encodings (OP_ADD=0, OP_SUB=1, OP_ACC_ADD=2, OP_ACC_SUB=3) and the DIGITS derivation function.
- REQ-029: The nibble-to-segment decoder SHALL be the existing codebase sub-module bin7seg, instantiated once after the digit mux.

Verification (WIDTH=4, SCAN_DIV=4)
- REQ-030: a=3,b=5,op=0 -> next cycle result=8, carry=0, ovf=1, zero=0, out_valid=1 for one cycle.
- REQ-031: a=5,b=3,op=1 -> result=2, carry=1, ovf=0; then a=3,b=5,op=1 -> result=14, carry=0, ovf=0.
- REQ-032: a=8,b=8,op=0 -> result=0, carry=1, ovf=1, zero=1; display digit1 shows 1.
- REQ-033: With ADDSUB_ACCUM_EN: reset, then three cycles op=2,b=6 -> results 6, 12, 2 (carry=1 on third); without the macro, same stimulus with a=0 -> 6, 6, 6.
- REQ-034: Idle 16 cycles -> an sequence 01,10,01,10 each held 4 cycles; assert rst with in_valid=1 mid-scan -> no out_valid, all REQ-025 values next cycle.
